regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write register file with a per-register
// scoreboard. Each register has a busy bit that marks an outstanding producer.
// Register 0 always reads zero and is never busy. Reads are combinational and
// forward same-cycle writes. busy_cnt is a registered count of busy registers.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         wr0_en,
    input  logic [ADDR_W-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_W-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic                         iss_en,
    input  logic [ADDR_W-1:0]            iss_addr,
    output logic [ADDR_W:0]              busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    // Storage and scoreboard state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  busy_cnt_q;
    logic [CNT_W-1:0]  busy_cnt_d;

    // Qualified strobes: anything aimed at register 0 is dropped here
    logic wr0_hit;
    logic wr1_hit;
    logic iss_hit;

    assign wr0_hit = wr0_en && (wr0_addr != '0);
    assign wr1_hit = wr1_en && (wr1_addr != '0);
    assign iss_hit = iss_en && (iss_addr != '0);

    // Data storage: port 1 is written last so it wins an address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0_hit) begin
                mem_q[wr0_addr] <= wr0_data;
            end
            if (wr1_hit) begin
                mem_q[wr1_addr] <= wr1_data;
            end
        end
    end

    // Next busy vector: writes retire a producer, an issue on the same
    // register applies afterwards so the newer producer keeps it busy
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            if ((wr0_hit && (wr0_addr == ADDR_W'(i))) ||
                (wr1_hit && (wr1_addr == ADDR_W'(i)))) begin
                busy_d[i] = 1'b0;
            end
            if (iss_hit && (iss_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Population count of the next busy vector feeds the registered counter
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // Scoreboard and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read ports: storage lookup with same-cycle write forwarding
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        logic [DATA_W-1:0] data_c;
        logic              busy_c;

        assign addr_c = rd_addr[k*ADDR_W +: ADDR_W];

        // Forwarding priority: wr1 over wr0 over stored contents
        always_comb begin
            data_c = mem_q[addr_c];
            busy_c = busy_q[addr_c];
            if (wr0_hit && (wr0_addr == addr_c)) begin
                data_c = wr0_data;
                busy_c = 1'b0;
            end
            if (wr1_hit && (wr1_addr == addr_c)) begin
                data_c = wr1_data;
                busy_c = 1'b0;
            end
            if (addr_c == '0) begin
                data_c = '0;
                busy_c = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_c;
        assign rd_busy[k]                  = busy_c;
    end

endmodule
